// File: rtl/pixel_stream_proc.sv
// Streaming RGB point processor. Latches the operation per frame, registers one
// output beat with SOF/EOL/EOF sideband and inserts a horizontal blank between lines.
module pixel_stream_proc #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int PPC    = 2,
    parameter int CW     = 8,
    parameter int HBLANK = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  start,
    input  logic [2:0]            mode,
    input  logic [CW-1:0]         value,
    input  logic [CW-1:0]         threshold,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [PPC*3*CW-1:0]   s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [PPC*3*CW-1:0]   m_data,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof,
    output logic                  busy,
    output logic                  ctrl_done,
    output logic [15:0]           frame_cnt
);
    localparam int PW   = 3 * CW;
    localparam int DW   = PPC * PW;
    localparam int COLW = $clog2(WIDTH + 1);
    localparam int ROWW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BLW  = (HBLANK > 1) ? $clog2(HBLANK) : 1;

    localparam logic [COLW-1:0] COL_LAST   = COLW'(WIDTH - PPC);
    localparam logic [COLW-1:0] COL_STEP   = COLW'(PPC);
    localparam logic [ROWW-1:0] ROW_LAST   = ROWW'(HEIGHT - 1);
    localparam logic [ROWW-1:0] ROW_ONE    = ROWW'(1);
    localparam logic [BLW-1:0]  BLANK_LAST = BLW'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [BLW-1:0]  BLANK_ONE  = BLW'(1);
    localparam logic [CW-1:0]   MAX        = '1;
    localparam logic [CW+1:0]   THREE      = (CW+2)'(3);

    localparam logic [2:0] MODE_ADD = 3'd1;
    localparam logic [2:0] MODE_SUB = 3'd2;
    localparam logic [2:0] MODE_INV = 3'd3;
    localparam logic [2:0] MODE_THR = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK, S_DRAIN} state_e;

    state_e          state_q, state_d;
    logic [COLW-1:0] col_q, col_d;
    logic [ROWW-1:0] row_q, row_d;
    logic [BLW-1:0]  blank_q, blank_d;
    logic [2:0]      mode_q, mode_d;
    logic [CW-1:0]   value_q, value_d;
    logic [CW-1:0]   thr_q, thr_d;
    logic            m_valid_q, m_valid_d;
    logic [DW-1:0]   m_data_q, m_data_d;
    logic            m_sof_q, m_sof_d;
    logic            m_eol_q, m_eol_d;
    logic            m_eof_q, m_eof_d;
    logic            done_q, done_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [DW-1:0]   proc_data;
    logic            accept, handshake;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CW] ? MAX : s[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] sat_sub(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    function automatic logic [PW-1:0] proc_pixel(input logic [PW-1:0] px, input logic [2:0] op,
                                                 input logic [CW-1:0] val, input logic [CW-1:0] thr);
        logic [CW-1:0] r, g, b, avg, grey, bin;
        logic [CW+1:0] sum;
        r    = px[2*CW +: CW];
        g    = px[CW +: CW];
        b    = px[0 +: CW];
        sum  = {2'b00, r} + {2'b00, g} + {2'b00, b};
        avg  = CW'(sum / THREE);
        grey = MAX - avg;
        bin  = (avg > thr) ? MAX : '0;
        case (op)
            MODE_ADD: return {sat_add(r, val), sat_add(g, val), sat_add(b, val)};
            MODE_SUB: return {sat_sub(r, val), sat_sub(g, val), sat_sub(b, val)};
            MODE_INV: return {grey, grey, grey};
            MODE_THR: return {bin, bin, bin};
            default:  return px;
        endcase
    endfunction

    for (genvar k = 0; k < PPC; k++) begin : g_pix
        assign proc_data[k*PW +: PW] = proc_pixel(s_data[k*PW +: PW], mode_q, value_q, thr_q);
    end

    // A new beat may enter only when the output register is empty or draining this cycle.
    assign s_ready   = !HRESET && (state_q == S_ACTIVE) && (!m_valid_q || m_ready);
    assign accept    = s_valid && s_ready;
    assign handshake = m_valid_q && m_ready;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        blank_d     = blank_q;
        mode_d      = mode_q;
        value_d     = value_q;
        thr_d       = thr_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_sof_d     = m_sof_q;
        m_eol_d     = m_eol_q;
        m_eof_d     = m_eof_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = proc_data;
            m_sof_d   = (row_q == '0) && (col_q == '0);
            m_eol_d   = (col_q == COL_LAST);
            m_eof_d   = (col_q == COL_LAST) && (row_q == ROW_LAST);
        end else if (handshake) begin
            m_valid_d = 1'b0;
            m_sof_d   = 1'b0;
            m_eol_d   = 1'b0;
            m_eof_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    value_d = value;
                    thr_d   = threshold;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + ROW_ONE;
                            if (HBLANK > 0) state_d = S_BLANK;
                        end
                    end else begin
                        col_d = col_q + COL_STEP;
                    end
                end
            end
            S_BLANK: begin
                if (blank_q == BLANK_LAST) begin
                    blank_d = '0;
                    state_d = S_ACTIVE;
                end else begin
                    blank_d = blank_q + BLANK_ONE;
                end
            end
            S_DRAIN: begin
                if (handshake && m_eof_q) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // independent of statement order.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            blank_q     <= '0;
            mode_q      <= '0;
            value_q     <= '0;
            thr_q       <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_sof_q     <= 1'b0;
            m_eol_q     <= 1'b0;
            m_eof_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            blank_q     <= blank_d;
            mode_q      <= mode_d;
            value_q     <= value_d;
            thr_q       <= thr_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_sof_q     <= m_sof_d;
            m_eol_q     <= m_eol_d;
            m_eof_q     <= m_eof_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_sof     = m_sof_q;
    assign m_eol     = m_eol_q;
    assign m_eof     = m_eof_q;
    assign busy      = (state_q != S_IDLE);
    assign ctrl_done = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Self-checking bench for pixel_stream_proc: directed frames with random pixel
// payloads, scored against a plain-arithmetic model of the point operations.
module tb_pixel_stream_proc;
    localparam int W           = 8;
    localparam int H           = 2;
    localparam int PPC         = 2;
    localparam int CW          = 8;
    localparam int HB          = 3;
    localparam int DW          = PPC * 3 * CW;
    localparam int LINE_BEATS  = W / PPC;
    localparam int FRAME_BEATS = LINE_BEATS * H;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          start;
    logic [2:0]    mode;
    logic [CW-1:0] value;
    logic [CW-1:0] threshold;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_sof, m_eol, m_eof, busy, ctrl_done;
    logic [15:0]   frame_cnt;

    pixel_stream_proc #(.WIDTH(W), .HEIGHT(H), .PPC(PPC), .CW(CW), .HBLANK(HB)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .mode(mode), .value(value),
        .threshold(threshold), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
        .m_eol(m_eol), .m_eof(m_eof), .busy(busy), .ctrl_done(ctrl_done),
        .frame_cnt(frame_cnt)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    beat_t         exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            ref_mode, ref_val, ref_thr;
    int            in_idx, out_cnt, done_cnt, exp_frames;
    logic [15:0]   done_fc;
    logic          done_busy;
    logic          last_sready, last_mvalid, last_emit, last_accept;
    logic [DW-1:0] last_mdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference point operation on one pixel, straight from the arithmetic rules.
    function automatic logic [23:0] ref_pixel(input logic [23:0] px);
        int c[3];
        int o[3];
        int avg;
        c[0] = int'(px[23:16]);
        c[1] = int'(px[15:8]);
        c[2] = int'(px[7:0]);
        avg  = (c[0] + c[1] + c[2]) / 3;
        for (int i = 0; i < 3; i++) begin
            case (ref_mode)
                1:       o[i] = (c[i] + ref_val > 255) ? 255 : c[i] + ref_val;
                2:       o[i] = (c[i] - ref_val < 0) ? 0 : c[i] - ref_val;
                3:       o[i] = 255 - avg;
                4:       o[i] = (avg > ref_thr) ? 255 : 0;
                default: o[i] = c[i];
            endcase
        end
        return {8'(o[0]), 8'(o[1]), 8'(o[2])};
    endfunction

    function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int k = 0; k < PPC; k++) r[k*24 +: 24] = ref_pixel(d[k*24 +: 24]);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // One clock: observe at the falling edge, score handshakes, then step past the rising edge.
    task automatic tick();
        beat_t e;
        @(negedge HCLK);
        last_sready = s_ready;
        last_mvalid = m_valid;
        last_mdata  = m_data;
        last_emit   = 1'b0;
        last_accept = 1'b0;
        if (ctrl_done === 1'b1) begin
            done_cnt++;
            done_fc   = frame_cnt;
            done_busy = busy;
        end
        if (m_valid === 1'b1 && m_ready) begin
            last_emit = 1'b1;
            out_cnt++;
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("m_data", m_data, e.d);
                check("m_sof", m_sof, e.sof);
                check("m_eol", m_eol, e.eol);
                check("m_eof", m_eof, e.eof);
            end
        end
        if (s_valid && s_ready === 1'b1) begin
            last_accept = 1'b1;
            e.d   = ref_beat(s_data);
            e.sof = (in_idx == 0);
            e.eol = (in_idx % LINE_BEATS) == LINE_BEATS - 1;
            e.eof = (in_idx == FRAME_BEATS - 1);
            exp_q.push_back(e);
            in_idx++;
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic run_frame(input logic [2:0] md, input logic [7:0] val, input logic [7:0] thr,
                             input logic [DW-1:0] beat0, input logic [DW-1:0] exp0,
                             input int stall_at, input int abort_at, input bit mid_start);
        int            idx, guard, idx_before, blank_low, done0;
        bit            stalled, prev_accept;
        logic [DW-1:0] hold, first_out;
        mode = md; value = val; threshold = thr; start = 1'b1;
        ref_mode = int'(md); ref_val = int'(val); ref_thr = int'(thr);
        in_idx = 0; out_cnt = 0; done0 = done_cnt;
        tick();
        start = 1'b0;
        check("busy_in_frame", busy, 1);
        idx = 0; guard = 0; blank_low = 0; stalled = 0; prev_accept = 0; first_out = '0;
        s_data = beat0;
        s_valid = 1'b1;
        while (idx < FRAME_BEATS && guard < 200) begin
            if (mid_start && idx == 3) begin
                start = 1'b1; mode = 3'd4; value = ~val; threshold = 8'd0;
            end
            if (idx == 5) start = 1'b0;
            if (abort_at >= 0 && idx == abort_at) begin
                HRESET = 1'b1;
                s_valid = 1'b0;
                tick();
                HRESET = 1'b0;
                exp_q.delete();
                check("abort_m_valid", m_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_frame_cnt", frame_cnt, 0);
                check("abort_s_ready", s_ready, 0);
                repeat (5) tick();
                check("abort_no_done", done_cnt - done0, 0);
                check("abort_idle_out", out_cnt, abort_at);
                exp_frames = 0;
                return;
            end
            if (stall_at >= 0 && idx == stall_at && !stalled) begin
                stalled = 1;
                m_ready = 1'b0;
                tick();
                hold = last_mdata;
                check("stall_m_valid", last_mvalid, 1);
                check("stall_s_ready", last_sready, 0);
                repeat (4) begin
                    tick();
                    check("stall_s_ready", last_sready, 0);
                    check("stall_hold", last_mdata, hold);
                end
                m_ready = 1'b1;
            end
            idx_before = idx;
            tick();
            guard++;
            if (stall_at < 0 && prev_accept) check("latency", last_emit, 1);
            if (last_emit && out_cnt == 1) first_out = last_mdata;
            if (!last_accept && idx_before == LINE_BEATS && !last_sready) blank_low++;
            prev_accept = last_accept;
            if (last_accept) begin
                idx++;
                s_data = rand_beat();
            end
        end
        s_valid = 1'b0;
        start = 1'b0;
        check("frame_accepts", idx, FRAME_BEATS);
        guard = 0;
        while (done_cnt == done0 && guard < 20) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        exp_frames++;
        check("out_beats", out_cnt, FRAME_BEATS);
        check("done_pulses", done_cnt - done0, 1);
        check("done_frame_cnt", done_fc, 16'(exp_frames));
        check("done_busy", done_busy, 0);
        check("busy_idle", busy, 0);
        check("frame_cnt", frame_cnt, 16'(exp_frames));
        check("queue_empty", exp_q.size(), 0);
        check("first_beat", first_out, exp0);
        if (stall_at < 0) check("blank_cycles", blank_low, HB);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1; start = 1'b0; mode = '0; value = '0; threshold = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        done_cnt = 0; exp_frames = 0; in_idx = 0; out_cnt = 0;
        repeat (2) tick();
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_sof", m_sof, 0);
        check("rst_m_eol", m_eol, 0);
        check("rst_m_eof", m_eof, 0);
        check("rst_busy", busy, 0);
        check("rst_ctrl_done", ctrl_done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        HRESET = 1'b0;
        tick();
        check("idle_s_ready", s_ready, 0);

        // Brightness add with saturation, full frame timing.
        run_frame(3'd1, 8'd100, 8'd0, {24'h000000, 24'hC8329B}, {24'h646464, 24'hFF96FF}, -1, -1, 0);
        // Brightness subtract with clamp to zero.
        run_frame(3'd2, 8'd100, 8'd0, {24'hFF0064, 24'h3C64FF}, {24'h9B0000, 24'h00009B}, -1, -1, 0);
        // Grey invert.
        run_frame(3'd3, 8'd0, 8'd0, {24'h000000, 24'h0A141F}, {24'hFFFFFF, 24'hEBEBEB}, -1, -1, 0);
        // Threshold: equality gives 0, one above gives MAX.
        run_frame(3'd4, 8'd0, 8'd90, {24'h5B5B5B, 24'h5A5A5B}, {24'hFFFFFF, 24'h000000}, -1, -1, 0);
        // Backpressure mid-line.
        run_frame(3'd0, 8'd0, 8'd0, {24'h123456, 24'hABCDEF}, {24'h123456, 24'hABCDEF}, 2, -1, 0);
        // start and mode toggled mid-frame must not disturb the frame.
        run_frame(3'd1, 8'd20, 8'd0, {24'hF0F0F0, 24'h010203}, {24'hFFFFFF, 24'h151617}, -1, -1, 1);
        // Reset after three beats drops the frame.
        run_frame(3'd3, 8'd0, 8'd0, {24'h102030, 24'h405060}, '0, -1, 3, 0);
        // Clean frame after reset, threshold just around the level.
        run_frame(3'd4, 8'd0, 8'h80, {24'h808080, 24'h818181}, {24'h000000, 24'hFFFFFF}, -1, -1, 0);
        // Reserved mode code behaves as passthrough.
        run_frame(3'd6, 8'd55, 8'd10, {24'hDEADBE, 24'hEF0123}, {24'hDEADBE, 24'hEF0123}, -1, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_stream_proc.md
Name: pixel_stream_proc

Overview:
- Parametrised, streaming successor to the frame-buffer image reader and processor.
- Accepts RGB pixels over a valid/ready input stream, PPC pixels per beat.
- Applies a run-time-selected point operation: passthrough, saturating brightness add/sub, grey invert, or threshold.
- Emits one registered output stream with start-of-frame, end-of-line and end-of-frame sideband, inserts a configurable horizontal blank between lines, and pulses a done flag per frame.

Parameters:
- WIDTH, 768, pixels per line; must be a multiple of PPC.
- HEIGHT, 512, lines per frame.
- PPC, 2, pixels carried per beat (1..8).
- CW, 8, bits per colour component.
- HBLANK, 16, idle cycles inserted between lines; 0 means no gap.

Ports:
- HCLK  in  1  clock; all logic on the rising edge.
- HRESET  in  1  synchronous reset, active-high.
- start  in  1  frame start request; sampled in IDLE only.
- mode  in  3  0 pass, 1 bright-add, 2 bright-sub, 3 invert, 4 threshold, 5-7 pass.
- value  in  CW  brightness offset.
- threshold  in  CW  threshold level.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  PPC*3*CW  pixel k at [k*3*CW +: 3*CW]; within a pixel R is the MS field, then G, then B in the LSBs.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  PPC*3*CW  processed pixels, same packing as s_data.
- m_sof  out  1  first beat of frame.
- m_eol  out  1  last beat of line.
- m_eof  out  1  last beat of frame.
- busy  out  1  state != IDLE.
- ctrl_done  out  1  one-cycle frame-complete pulse.
- frame_cnt  out  16  completed frames; wraps at 65535 -> 0.

Behaviour:
- Reset (HRESET=1 at edge):
  - state=IDLE; col, row and blank counter = 0.
  - m_valid, m_sof, m_eol, m_eof, ctrl_done, busy = 0; m_data = 0; frame_cnt = 0.
  - s_ready = 0 while in reset and while IDLE.
  - A reset mid-frame drops the partial frame: no ctrl_done, frame_cnt unchanged from its reset value of 0.
- States:
  - IDLE: start=1 latches mode, value and threshold into shadow registers, then -> ACTIVE. Mid-frame changes to these inputs have no effect.
  - ACTIVE: s_ready = !m_valid || m_ready. On each accepted beat, col += PPC.
    - Accepted beat with col == WIDTH-PPC: col <= 0, row += 1.
    - If row == HEIGHT-1 -> DRAIN; else if HBLANK > 0 -> BLANK; else stay in ACTIVE.
  - BLANK: s_ready = 0. Counter runs 0..HBLANK-1, then -> ACTIVE. Exactly HBLANK cycles with s_ready low.
  - DRAIN: s_ready = 0. When the m_eof beat handshakes (m_valid && m_ready), -> IDLE.
    - ctrl_done = 1 on the following cycle for exactly one cycle; frame_cnt increments on that same cycle.
  - start outside IDLE is ignored.
- Pipeline:
  - One register stage. An input accepted at edge N is presented on m_valid/m_data at edge N (visible in cycle N+1); latency 1 cycle.
  - Full throughput when m_ready = 1.
  - While m_valid && !m_ready: m_data and sideband hold stable and s_ready = 0.
  - m_sof is set on beat (row 0, col 0); m_eol on col == WIDTH-PPC; m_eof on m_eol of row HEIGHT-1.
- Arithmetic, per pixel, all PPC pixels in parallel, MAX = 2^CW-1:
  - bright-add: c + value, saturated to MAX (CW+1-bit intermediate).
  - bright-sub: c - value, clamped to 0.
  - avg = floor((R+G+B)/3), computed from a (CW+2)-bit sum.
  - invert: R = G = B = MAX - avg.
  - threshold: R = G = B = (avg > threshold) ? MAX : 0. Strictly greater than; equality gives 0.
  - pass: unchanged.
- Simultaneous accept and emit in the same cycle is legal and loses no data.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=2, PPC=2, CW=8, HBLANK=3.
1. mode=1, value=100, pixel (200,50,155) -> (255,150,255); pixel (0,0,0) -> (100,100,100); output 1 cycle after accept.
2. mode=2, value=100, pixel (60,100,255) -> (0,0,155).
3. mode=3, pixel (10,20,31): avg=20 -> (235,235,235). mode=4, threshold=90: (90,90,91) avg=90 -> (0,0,0); (91,91,91) -> (255,255,255).
4. Full frame, m_ready=1:
   - 8 output beats total.
   - m_sof on beat 1; m_eol on beats 4 and 8; m_eof on beat 8.
   - s_ready low for exactly 3 cycles after the 4th accept.
   - ctrl_done single pulse; frame_cnt 0 -> 1; busy drops.
5. Backpressure: hold m_ready=0 for 5 cycles mid-line -> s_ready=0, m_data stable, no beats lost or duplicated; frame still yields 8 beats in order.
6. Control robustness:
   - start re-asserted and mode changed mid-frame -> no effect on the current frame.
   - HRESET=1 after 3 beats -> m_valid=0, state=IDLE, frame_cnt=0, no ctrl_done.
   - Subsequent start -> a clean full frame.
